// File: rtl/tone_gen_pkg.sv
// tone_gen_pkg: widths, defaults and state encoding shared by the tone generator
// and the key decoder that drives it.
package tone_gen_pkg;

    localparam int NOTE_W      = 16;
    localparam int TICK_HZ_DEF = 1_000_000;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler giving a one-cycle tick every DIV clocks; clr holds it at phase 0.
module tick_gen #(
    parameter int DIV = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int W = DIV > 1 ? $clog2(DIV) : 1;

    logic [W-1:0] pcnt;

    // with DIV==1 pcnt stays 0 and tick is permanently high
    assign tick = pcnt == W'(DIV - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pcnt <= '0;
        else
            pcnt <= (clr || tick) ? '0 : pcnt + W'(1);
    end

endmodule

// File: rtl/tone_gen.sv
// tone_gen: square-wave buzzer driver; toggles beep every m ticks, with pitch
// changes and stops applied only at half-period boundaries.
module tone_gen
    import tone_gen_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = TICK_HZ_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NOTE_W-1:0] m,
    output logic              beep,
    output logic              active
);

    localparam int DIV = CLK_HZ / TICK_HZ;

    state_t            state, state_nx;
    logic [NOTE_W-1:0] hcnt, hcnt_nx, m_q, m_q_nx;
    logic              beep_nx, tick, go, bnd;

    tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (state == IDLE),
        .tick (tick)
    );

    assign go  = en && (m != '0);
    // m_q is never 0 in PLAY, so m_q-1 cannot underflow there
    assign bnd = (state == PLAY) && tick && (hcnt == m_q - NOTE_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            hcnt   <= '0;
            m_q    <= '0;
            beep   <= 1'b0;
            active <= 1'b0;
        end else begin
            state  <= state_nx;
            hcnt   <= hcnt_nx;
            m_q    <= m_q_nx;
            beep   <= beep_nx;
            active <= state_nx == PLAY;
        end
    end

    always_comb begin
        state_nx = state;
        if (state == IDLE)
            state_nx = go ? PLAY : IDLE;
        else if (bnd && !go)
            state_nx = IDLE;
    end

    always_comb begin
        hcnt_nx = (state == IDLE || bnd) ? '0 : (tick ? hcnt + NOTE_W'(1) : hcnt);
        m_q_nx  = ((state == IDLE || bnd) && go) ? m : m_q;
        beep_nx = (state == IDLE) ? go : (bnd ? (go && !beep) : beep);
    end

endmodule

// File: tb/tb_tone_gen.sv
// tb_tone_gen: checks tone_gen (DIV=4, plus a DIV=1 copy for the 0xFFFF half-period)
// against a clock-counting model of the buzzer waveform.
module tb_tone_gen;

    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0;
    logic [15:0] m = '0, m1 = '0;
    logic        beep, active, beep1, active1;
    int          errs = 0, checks = 0;

    tone_gen #(.CLK_HZ(4), .TICK_HZ(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .m(m), .beep(beep), .active(active)
    );

    tone_gen #(.CLK_HZ(1), .TICK_HZ(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .m(m1), .beep(beep1), .active(active1)
    );

    always #5 clk = ~clk;

    // model: remaining clocks of the current half-period, counted down per clock
    typedef struct {bit play; bit lvl; int rem;} mdl_t;
    mdl_t r0 = '{0, 0, 0};
    mdl_t r1 = '{0, 0, 0};

    function automatic mdl_t step(mdl_t s, bit e, int mv, int div);
        mdl_t n = s;
        if (!s.play) begin
            if (e && mv != 0) begin
                n.play = 1; n.lvl = 1; n.rem = mv * div;
            end
        end else begin
            n.rem = s.rem - 1;
            if (n.rem == 0) begin
                if (e && mv != 0) begin
                    n.lvl = !s.lvl; n.rem = mv * div;
                end else begin
                    n.play = 0; n.lvl = 0;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0 <= '{0, 0, 0};
            r1 <= '{0, 0, 0};
        end else begin
            r0 <= step(r0, en, int'(m), 4);
            r1 <= step(r1, en, int'(m1), 1);
        end
    end

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            check("beep", beep, r0.lvl);
            check("active", active, r0.play);
            check("beep1", beep1, r1.lvl);
            check("active1", active1, r1.play);
        end
    endtask

    task automatic wait_mid(input bit lvl);
        for (int i = 0; i < 200 && !(r0.play && r0.lvl == lvl && r0.rem > 4 && r0.rem < 10); i++)
            @(negedge clk);
    endtask

    initial begin
        en = 1'b1; m = 16'd3;
        run(3);
        check("rst_beep", beep, 1'b0);
        check("rst_active", active, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("start_wait", beep, 1'b0);
        run(60);
        wait_mid(1'b1);
        m = 16'd5;
        run(90);
        wait_mid(1'b1);
        m = 16'd0;
        run(30);
        check("stopped", active, 1'b0);
        m = 16'd3;
        run(40);
        m = 16'd1;
        run(30);
        m = 16'd3;
        wait_mid(1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_beep", beep, 1'b0);
        check("async_active", active, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run(40);
        wait_mid(1'b0);
        en = 1'b0;
        run(30);
        check("en_idle", active, 1'b0);
        en = 1'b1;
        run(40);
        repeat (60) begin
            m  = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 5));
            en = $urandom_range(0, 7) != 0;
            run($urandom_range(1, 15));
        end
        en = 1'b1; m = 16'd3;
        m1 = 16'hFFFF;
        run(3);
        check("ffff_start", beep1, 1'b1);
        run(65536);
        check("ffff_toggled", beep1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
